// File: rtl/vga_bus_frontend.sv
// Bus-side front end for the VGA frame buffer: register file, pixel write FIFO,
// full-frame fill engine and status read-back, draining to frame-buffer port A.
module vga_bus_frontend #(
    parameter logic [7:0]  BASE_ADDR  = 8'hB0,
    parameter int unsigned X_BITS     = 8,
    parameter int unsigned Y_BITS     = 7,
    parameter int unsigned HOR_RES    = 160,
    parameter int unsigned VERT_RES   = 120,
    parameter int unsigned PIX_BITS   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [7:0]                 BUS_ADDR,
    inout  wire  [7:0]                 BUS_DATA,
    input  logic                       BUS_WE,
    output logic [X_BITS+Y_BITS-1:0]   FB_ADDR,
    output logic [PIX_BITS-1:0]        FB_DATA,
    output logic                       FB_WE,
    output logic [15:0]                CONFIG_COLOURS,
    output logic                       BUSY
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = Y_BITS + X_BITS + PIX_BITS;
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(HOR_RES - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(VERT_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_DRAIN, S_FILL} fill_state_t;

    fill_state_t state, state_d;

    logic [X_BITS-1:0]   x_reg, fill_x;
    logic [Y_BITS-1:0]   y_reg, fill_y;
    logic [7:0]          fg_reg, bg_reg;
    logic [PIX_BITS-1:0] fill_val, fill_val_cap;
    logic                auto_inc, ovf;

    logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full, pop, push;

    logic [7:0]          bus_din, rd_data;
    logic                in_range;
    logic [2:0]          reg_sel;
    logic                wr_en, wr_x, wr_y, wr_pix, wr_fg, wr_bg, wr_ctrl, wr_fill;
    logic                fill_go, fill_last;
    logic [X_BITS-1:0]   x_wr_val;
    logic [Y_BITS-1:0]   y_wr_val;

    // Decode in 9 bits so a BASE_ADDR near 8'hFF cannot alias low addresses.
    assign in_range = ({1'b0, BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, BUS_ADDR} <= ({1'b0, BASE_ADDR} + 9'd7));
    assign reg_sel  = 3'(BUS_ADDR - BASE_ADDR);
    assign bus_din  = BUS_DATA;

    assign wr_en   = BUS_WE && in_range;
    assign wr_x    = wr_en && (reg_sel == 3'd0);
    assign wr_y    = wr_en && (reg_sel == 3'd1);
    assign wr_pix  = wr_en && (reg_sel == 3'd2);
    assign wr_fg   = wr_en && (reg_sel == 3'd3);
    assign wr_bg   = wr_en && (reg_sel == 3'd4);
    assign wr_ctrl = wr_en && (reg_sel == 3'd5);
    assign wr_fill = wr_en && (reg_sel == 3'd7);

    assign x_wr_val = (32'(bus_din) >= HOR_RES)  ? X_MAX : X_BITS'(bus_din);
    assign y_wr_val = (32'(bus_din) >= VERT_RES) ? Y_MAX : Y_BITS'(bus_din);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Draining continues in WAIT_DRAIN, otherwise that state could never exit.
    assign pop   = !empty && (state != S_FILL);
    assign push  = wr_pix && (!full || pop);

    assign fill_go   = wr_ctrl && bus_din[1] && (state == S_IDLE);
    assign fill_last = (fill_x == X_MAX) && (fill_y == Y_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x_reg        <= '0;
            y_reg        <= '0;
            fg_reg       <= 8'hFF;
            bg_reg       <= 8'h15;
            fill_val     <= '0;
            fill_val_cap <= '0;
            auto_inc     <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            if (wr_x) x_reg <= x_wr_val;
            if (wr_y) y_reg <= y_wr_val;
            if (wr_pix && auto_inc) begin
                if (x_reg == X_MAX) begin
                    x_reg <= '0;
                    y_reg <= (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
                end else begin
                    x_reg <= x_reg + 1'b1;
                end
            end
            if (wr_fg)   fg_reg   <= bus_din;
            if (wr_bg)   bg_reg   <= bus_din;
            if (wr_ctrl) auto_inc <= bus_din[0];
            if (wr_fill) fill_val <= bus_din[PIX_BITS-1:0];
            if (wr_ctrl && bus_din[7])
                ovf <= 1'b0;
            else if (wr_pix && full && !pop)
                ovf <= 1'b1;
            if (fill_go) fill_val_cap <= fill_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {y_reg, x_reg, bus_din[PIX_BITS-1:0]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:       if (fill_go)   state_d = S_WAIT_DRAIN;
            S_WAIT_DRAIN: if (empty)     state_d = S_FILL;
            S_FILL:       if (fill_last) state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            FB_WE   <= 1'b0;
            FB_ADDR <= '0;
            FB_DATA <= '0;
            fill_x  <= '0;
            fill_y  <= '0;
        end else if (state == S_FILL) begin
            FB_WE   <= 1'b1;
            FB_ADDR <= {fill_y, fill_x};
            FB_DATA <= fill_val_cap;
            if (fill_x == X_MAX) begin
                fill_x <= '0;
                fill_y <= fill_y + 1'b1;
            end else begin
                fill_x <= fill_x + 1'b1;
            end
        end else begin
            fill_x <= '0;
            fill_y <= '0;
            FB_WE  <= pop;
            if (pop) {FB_ADDR, FB_DATA} <= fifo_mem[rd_ptr[AW-1:0]];
        end
    end

    assign CONFIG_COLOURS = {fg_reg, bg_reg};
    assign BUSY           = (state != S_IDLE) || !empty;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = 8'(x_reg);
            3'd1:    rd_data = 8'(y_reg);
            3'd3:    rd_data = fg_reg;
            3'd4:    rd_data = bg_reg;
            3'd5:    rd_data = {7'b0, auto_inc};
            3'd6:    rd_data = {ovf, 3'b0, 1'b0, (state != S_IDLE), full, empty};
            3'd7:    rd_data = 8'(fill_val);
            default: rd_data = '0;
        endcase
    end

    assign BUS_DATA = (!BUS_WE && in_range) ? rd_data : 8'bz;

endmodule

// File: tb/tb_vga_bus_frontend.sv
// Randomised self-checking bench for vga_bus_frontend against a register-level
// behavioural model of the bus map, auto-increment and pixel ordering.
module tb_vga_bus_frontend;

    localparam logic [7:0]  BASE     = 8'hB0;
    localparam int unsigned HR       = 160;
    localparam int unsigned VR       = 120;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned FILL_PIX = HR * VR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_we = 1'b0;
    logic        drv_en = 1'b0;
    logic [7:0]  bus_addr = 8'h00;
    logic [7:0]  drv_data = 8'h00;
    tri1  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data;
    logic        fb_we;
    logic [15:0] cfg;
    logic        busy;

    assign bus_data = drv_en ? drv_data : 8'bz;

    vga_bus_frontend #(
        .BASE_ADDR (BASE),
        .X_BITS    (8),
        .Y_BITS    (7),
        .HOR_RES   (HR),
        .VERT_RES  (VR),
        .PIX_BITS  (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .BUS_ADDR      (bus_addr),
        .BUS_DATA      (bus_data),
        .BUS_WE        (bus_we),
        .FB_ADDR       (fb_addr),
        .FB_DATA       (fb_data),
        .FB_WE         (fb_we),
        .CONFIG_COLOURS(cfg),
        .BUSY          (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned c;
        logic [15:0] v;
    } obs_t;

    obs_t        obs_q[$];
    logic [15:0] exp_q[$];

    // model state
    int unsigned m_x, m_y, m_fg, m_bg, m_auto, m_fill, m_ovf, m_pend;
    bit          m_stalled;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && fb_we) obs_q.push_back('{cyc, {fb_addr, fb_data}});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_fg = 8'hFF; m_bg = 8'h15;
        m_auto = 0; m_fill = 0; m_ovf = 0; m_pend = 0; m_stalled = 1'b0;
    endtask

    task automatic wr(input int unsigned off, input int unsigned data);
        @(negedge clk);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b1;
        drv_en   = 1'b1;
        drv_data = 8'(data);
        @(posedge clk);
        #1;
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        bus_addr = 8'h00;
        case (off)
            0: m_x = (data >= HR) ? HR - 1 : data;
            1: m_y = (data >= VR) ? VR - 1 : data;
            2: begin
                if (!m_stalled || m_pend < DEPTH) begin
                    exp_q.push_back({7'(m_y), 8'(m_x), 1'(data)});
                    if (m_stalled) m_pend++;
                end else begin
                    m_ovf = 1;
                end
                if (m_auto != 0) begin
                    if (m_x == HR - 1) begin
                        m_x = 0;
                        m_y = (m_y == VR - 1) ? 0 : m_y + 1;
                    end else begin
                        m_x++;
                    end
                end
            end
            3: m_fg = data & 8'hFF;
            4: m_bg = data & 8'hFF;
            5: begin
                m_auto = data & 1;
                if ((data & 8'h80) != 0) m_ovf = 0;
            end
            7: m_fill = data & 1;
            default: ;
        endcase
    endtask

    task automatic rd(input int unsigned off, output logic [7:0] data);
        @(negedge clk);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        #1;
        data = bus_data;
    endtask

    function automatic int unsigned model_read(input int unsigned off);
        case (off)
            0: return m_x;
            1: return m_y;
            3: return m_fg;
            4: return m_bg;
            5: return m_auto;
            7: return m_fill;
            default: return 0;
        endcase
    endfunction

    task automatic cmp_queues(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 32'(obs_q[i].v), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0]  v;
        int unsigned r, off, errs;

        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_cfg", 32'(cfg), 32'hFF15);
        check("rst_busy", 32'(busy), 32'd0);
        rd(6, v);
        check("rst_status", 32'(v), 32'h01);
        rd(0, v);
        check("rst_x", 32'(v), 32'd0);
        bus_addr = 8'h00;
        #1;
        check("rst_hiz", 32'(bus_data), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single pixel, latency checked edge by edge
        wr(0, 10);
        wr(1, 5);
        wr(2, 1);
        @(negedge clk);
        check("pix_we_edge_n", 32'(fb_we), 32'd0);
        @(negedge clk);
        check("pix_we_edge_n1", 32'(fb_we), 32'd1);
        check("pix_addr", 32'(fb_addr), 32'((5 << 8) | 10));
        check("pix_data", 32'(fb_data), 32'd1);
        @(negedge clk);
        check("pix_we_after", 32'(fb_we), 32'd0);
        obs_q.delete();
        exp_q.delete();

        // auto-increment wrap at the frame corner
        wr(5, 1);
        wr(0, 159);
        wr(1, 119);
        wr(2, 1);
        wr(2, 0);
        repeat (5) @(posedge clk);
        check("wrap_first", (obs_q.size() > 0) ? 32'(obs_q[0].v) : 32'hDEAD, 32'({7'd119, 8'd159, 1'b1}));
        cmp_queues("wrap_pix");
        rd(0, v);
        check("wrap_x", 32'(v), model_read(0));
        rd(1, v);
        check("wrap_y", 32'(v), model_read(1));

        // randomised register and pixel traffic
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0: wr(0, $urandom_range(0, 255));
                1: wr(1, $urandom_range(0, 255));
                2: wr(5, $urandom_range(0, 1));
                3: wr(3, $urandom_range(0, 255));
                4: wr(4, $urandom_range(0, 255));
                5: wr(7, $urandom_range(0, 255));
                6, 7: begin
                    off = $urandom_range(0, 6);
                    if (off == 6) off = 7;
                    rd(off, v);
                    check("rand_read", 32'(v), model_read(off));
                    check("rand_cfg", 32'(cfg), (m_fg << 8) | m_bg);
                end
                default: wr(2, $urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        repeat (8) @(posedge clk);
        cmp_queues("rand_pix");
        rd(6, v);
        check("rand_status", 32'(v), 32'h01);

        // fill with overflowing queued pixels
        wr(0, 20);
        wr(1, 30);
        wr(7, 1);
        repeat (3) @(posedge clk);
        obs_q.delete();
        exp_q.delete();
        wr(5, 8'h03);
        m_stalled = 1'b1;
        m_pend = 0;
        repeat (3) @(posedge clk);
        for (int n = 0; n < 5; n++) wr(2, $urandom_range(0, 255));
        rd(6, v);
        check("ovf_status", 32'(v), 32'h86);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_model", m_ovf, 32'd1);
        wr(5, 8'h80);
        rd(6, v);
        check("clr_ovf_status", 32'(v), 32'h06);
        rd(0, v);
        check("ovf_autoinc_x", 32'(v), model_read(0));
        for (int i = 0; i < 25000 && busy; i++) @(negedge clk);
        check("fill_done_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        m_stalled = 1'b0;
        check("fill_obs_count", 32'(obs_q.size()), FILL_PIX + 4);
        errs = 0;
        for (int i = 0; i < FILL_PIX && i < obs_q.size(); i++) begin
            if (obs_q[i].v !== {7'(i / HR), 8'(i % HR), 1'b1}) errs++;
            if (obs_q[i].c != obs_q[0].c + 32'(i)) errs++;
        end
        check("fill_seq_errs", errs, 32'd0);
        if (obs_q.size() >= FILL_PIX) begin
            for (int i = 0; i < FILL_PIX; i++) void'(obs_q.pop_front());
        end
        cmp_queues("fill_drain");
        rd(6, v);
        check("fill_status", 32'(v), 32'h01);

        // saturation, then reset asserted in the middle of a fill
        wr(0, 200);
        rd(0, v);
        check("x_sat", 32'(v), 32'd159);
        wr(1, 250);
        rd(1, v);
        check("y_sat", 32'(v), 32'd119);
        wr(5, 8'h02);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("fill_active", 32'(fb_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_fb_we", 32'(fb_we), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        check("post_rst_fb_we", 32'(fb_we), 32'd0);
        check("post_rst_cfg", 32'(cfg), 32'hFF15);
        rd(6, v);
        check("post_rst_status", 32'(v), 32'h01);
        rd(0, v);
        check("post_rst_x", 32'(v), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
